// File: rtl/regfile_pkg.sv
// Shared register-file widths, constants and the writeback request payload.
package regfile_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned NUM_REGS   = 2 ** ADDR_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] rd_index;
    logic [XLEN-1:0]       rd_data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after rr_ptr.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               hold,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] cand;
  logic [IDX_W:0]   sum;
  logic             found;

  // Scan from rr_ptr, wrapping modulo NUM_REQ (works for non-power-of-two counts).
  always_comb begin
    found = 1'b0;
    sel   = rr_ptr;
    sum   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // Grant is masked during reset so no handshake can complete while it is low.
  always_comb begin
    grant = '0;
    if (found && !hold && reset) begin
      grant[sel] = 1'b1;
    end
  end

  assign grant_idx = sel;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (|grant) begin
      rr_ptr <= (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + IDX_W'(1);
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates NUM_REQ writeback sources onto the single register-file write port
// through a one-cycle registered write stage; writes to x0 are swallowed.
module regfile_wb_arbiter #(
  parameter  int unsigned XLEN       = regfile_pkg::XLEN,
  parameter  int unsigned ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
  parameter  int unsigned NUM_REQ    = 2,
  localparam int unsigned SRC_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wb_hold,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_rd_index,
  input  logic [NUM_REQ*XLEN-1:0]       req_rd_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          rf_write_en,
  output logic [ADDR_WIDTH-1:0]         rf_rd_index,
  output logic [XLEN-1:0]               rf_rd,
  output logic [SRC_W-1:0]              wb_src,
  output logic [15:0]                   grant_count
);
  import regfile_pkg::*;

  logic [NUM_REQ-1:0] grant;
  logic [SRC_W-1:0]   grant_idx;
  wb_req_t            sel_req;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid),
    .hold      (wb_hold),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;

  // Select the winning request; valid doubles as "handshake this cycle".
  always_comb begin
    sel_req          = '0;
    sel_req.valid    = |grant;
    sel_req.rd_index = req_rd_index[32'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    sel_req.rd_data  = req_rd_data[32'(grant_idx)*XLEN +: XLEN];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rf_write_en <= 1'b0;
      rf_rd_index <= '0;
      rf_rd       <= '0;
      wb_src      <= '0;
      grant_count <= '0;
    end else begin
      rf_write_en <= sel_req.valid && (sel_req.rd_index != REG_ZERO);
      if (sel_req.valid) begin
        rf_rd_index <= sel_req.rd_index;
        rf_rd       <= sel_req.rd_data;
        wb_src      <= grant_idx;
      end
      if (sel_req.valid && (grant_count != 16'hFFFF)) begin
        grant_count <= grant_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vector table, hand sequences,
// and randomized traffic checked against a behavioural round-robin model.
module tb_regfile_wb_arbiter;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned N    = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            wb_hold;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_rd_index;
  logic [N*XLEN-1:0] req_rd_data;
  logic [N-1:0]    req_ready;
  logic            rf_write_en;
  logic [AW-1:0]   rf_rd_index;
  logic [XLEN-1:0] rf_rd;
  logic [0:0]      wb_src;
  logic [15:0]     grant_count;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .XLEN       (XLEN),
    .ADDR_WIDTH (AW),
    .NUM_REQ    (N)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wb_hold      (wb_hold),
    .req_valid    (req_valid),
    .req_rd_index (req_rd_index),
    .req_rd_data  (req_rd_data),
    .req_ready    (req_ready),
    .rf_write_en  (rf_write_en),
    .rf_rd_index  (rf_rd_index),
    .rf_rd        (rf_rd),
    .wb_src       (wb_src),
    .grant_count  (grant_count)
  );

  typedef struct {
    logic        rst;
    logic        hold;
    logic [1:0]  valid;
    logic [4:0]  i0;
    logic [4:0]  i1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  e_ready;
    logic        e_we;
    logic [4:0]  e_idx;
    logic [31:0] e_rd;
    logic        e_src;
    logic [15:0] e_cnt;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit          m_known = 1'b0;
  int          m_ptr;
  logic        m_we;
  logic [4:0]  m_idx;
  logic [31:0] m_rd;
  int          m_src;
  int          m_cnt;
  int          wait_cnt [N];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [1:0] v);
    for (int k = 0; k < int'(N); k++) begin
      int j;
      j = (m_ptr + k) % int'(N);
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic run(input vec_t t, input bit explicit_chk, input string tag);
    int         g;
    logic [1:0] m_ready;
    logic [4:0] g_idx;
    logic [31:0] g_dat;
    reset        = t.rst;
    wb_hold      = t.hold;
    req_valid    = t.valid;
    req_rd_index = {t.i1, t.i0};
    req_rd_data  = {t.d1, t.d0};
    @(negedge clk);
    g       = pick(t.valid);
    m_ready = (t.rst && !t.hold && g >= 0) ? 2'(1 << g) : 2'b00;
    if (explicit_chk) begin
      chk({tag, " ready"}, 32'(req_ready), 32'(t.e_ready));
      chk({tag, " we"},    32'(rf_write_en), 32'(t.e_we));
      chk({tag, " idx"},   32'(rf_rd_index), 32'(t.e_idx));
      chk({tag, " rd"},    rf_rd, t.e_rd);
      chk({tag, " src"},   32'(wb_src), 32'(t.e_src));
      chk({tag, " cnt"},   32'(grant_count), 32'(t.e_cnt));
    end
    if (m_known) begin
      chk({tag, " model ready"}, 32'(req_ready), 32'(m_ready));
      chk({tag, " model we"},    32'(rf_write_en), 32'(m_we));
      chk({tag, " model idx"},   32'(rf_rd_index), 32'(m_idx));
      chk({tag, " model rd"},    rf_rd, m_rd);
      chk({tag, " model src"},   32'(wb_src), 32'(m_src));
      chk({tag, " model cnt"},   32'(grant_count), 32'(m_cnt));
      // A continuously valid, unheld requester must win within N cycles.
      for (int j = 0; j < int'(N); j++) begin
        if (t.rst && !t.hold && t.valid[j]) begin
          wait_cnt[j] = req_ready[j] ? 0 : wait_cnt[j] + 1;
          chk({tag, " starve"}, 32'(wait_cnt[j] < int'(N)), 32'd1);
        end else begin
          wait_cnt[j] = 0;
        end
      end
    end
    if (!t.rst) begin
      m_known = 1'b1;
      m_ptr   = 0;
      m_we    = 1'b0;
      m_idx   = '0;
      m_rd    = '0;
      m_src   = 0;
      m_cnt   = 0;
      for (int j = 0; j < int'(N); j++) wait_cnt[j] = 0;
    end else if (m_ready != 2'b00) begin
      g_idx = (g == 0) ? t.i0 : t.i1;
      g_dat = (g == 0) ? t.d0 : t.d1;
      m_ptr = (g + 1) % int'(N);
      m_we  = (g_idx != 5'd0);
      m_idx = g_idx;
      m_rd  = g_dat;
      m_src = g;
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
    end else begin
      m_we = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];
  vec_t v;

  initial begin
    // power-up cycle, nothing known yet
    v = '{1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 1'b0, 5'd0, 32'h0, 1'b0, 16'd0};
    run(v, 1'b0, "powerup");

    // reset with both valid, release, single write, then round-robin
    vecs.push_back('{1'b0, 1'b0, 2'b11, 5'd5, 5'd9, 32'hDEADBEEF, 32'hCAFE0001, 2'b00, 1'b0, 5'd0, 32'h0, 1'b0, 16'd0});
    vecs.push_back('{1'b0, 1'b0, 2'b11, 5'd5, 5'd9, 32'hDEADBEEF, 32'hCAFE0001, 2'b00, 1'b0, 5'd0, 32'h0, 1'b0, 16'd0});
    vecs.push_back('{1'b1, 1'b0, 2'b11, 5'd5, 5'd9, 32'hDEADBEEF, 32'hCAFE0001, 2'b01, 1'b0, 5'd0, 32'h0, 1'b0, 16'd0});
    vecs.push_back('{1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 16'd1});
    vecs.push_back('{1'b1, 1'b0, 2'b10, 5'd0, 5'd7, 32'h0, 32'h77777777, 2'b10, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 16'd1});
    vecs.push_back('{1'b1, 1'b0, 2'b11, 5'd1, 5'd2, 32'h11111111, 32'h22222222, 2'b01, 1'b1, 5'd7, 32'h77777777, 1'b1, 16'd2});
    vecs.push_back('{1'b1, 1'b0, 2'b11, 5'd1, 5'd2, 32'h11111111, 32'h22222222, 2'b10, 1'b1, 5'd1, 32'h11111111, 1'b0, 16'd3});
    vecs.push_back('{1'b1, 1'b0, 2'b11, 5'd1, 5'd2, 32'h11111111, 32'h22222222, 2'b01, 1'b1, 5'd2, 32'h22222222, 1'b1, 16'd4});
    vecs.push_back('{1'b1, 1'b0, 2'b11, 5'd1, 5'd2, 32'h11111111, 32'h22222222, 2'b10, 1'b1, 5'd1, 32'h11111111, 1'b0, 16'd5});
    vecs.push_back('{1'b1, 1'b0, 2'b11, 5'd1, 5'd2, 32'h11111111, 32'h22222222, 2'b01, 1'b1, 5'd2, 32'h22222222, 1'b1, 16'd6});
    vecs.push_back('{1'b1, 1'b0, 2'b11, 5'd1, 5'd2, 32'h11111111, 32'h22222222, 2'b10, 1'b1, 5'd1, 32'h11111111, 1'b0, 16'd7});
    vecs.push_back('{1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 1'b1, 5'd2, 32'h22222222, 1'b1, 16'd8});
    // x0 write: handshake and count, but no register-file write
    vecs.push_back('{1'b1, 1'b0, 2'b10, 5'd0, 5'd0, 32'h0, 32'h12345678, 2'b10, 1'b0, 5'd2, 32'h22222222, 1'b1, 16'd8});
    vecs.push_back('{1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 1'b0, 5'd0, 32'h12345678, 1'b1, 16'd9});
    // wb_hold for three cycles, then release
    vecs.push_back('{1'b1, 1'b1, 2'b11, 5'd3, 5'd4, 32'h33333333, 32'h44444444, 2'b00, 1'b0, 5'd0, 32'h12345678, 1'b1, 16'd9});
    vecs.push_back('{1'b1, 1'b1, 2'b11, 5'd3, 5'd4, 32'h33333333, 32'h44444444, 2'b00, 1'b0, 5'd0, 32'h12345678, 1'b1, 16'd9});
    vecs.push_back('{1'b1, 1'b1, 2'b11, 5'd3, 5'd4, 32'h33333333, 32'h44444444, 2'b00, 1'b0, 5'd0, 32'h12345678, 1'b1, 16'd9});
    vecs.push_back('{1'b1, 1'b0, 2'b11, 5'd3, 5'd4, 32'h33333333, 32'h44444444, 2'b01, 1'b0, 5'd0, 32'h12345678, 1'b1, 16'd9});
    vecs.push_back('{1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 1'b1, 5'd3, 32'h33333333, 1'b0, 16'd10});

    for (int i = 0; i < vecs.size(); i++) begin
      run(vecs[i], 1'b1, $sformatf("vec%0d", i));
    end

    // Mid-operation reset: handshake, then reset on the edge after it; pointer returns to 0.
    v = '{1'b1, 1'b0, 2'b01, 5'd6, 5'd0, 32'h66666666, 32'h0, 2'b01, 1'b0, 5'd3, 32'h33333333, 1'b0, 16'd10};
    run(v, 1'b1, "midrst0");
    v = '{1'b0, 1'b0, 2'b11, 5'd1, 5'd2, 32'h11111111, 32'h22222222, 2'b00, 1'b1, 5'd6, 32'h66666666, 1'b0, 16'd11};
    run(v, 1'b1, "midrst1");
    v = '{1'b1, 1'b0, 2'b11, 5'd1, 5'd2, 32'h11111111, 32'h22222222, 2'b01, 1'b0, 5'd0, 32'h0, 1'b0, 16'd0};
    run(v, 1'b1, "midrst2");
    v = '{1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 1'b1, 5'd1, 32'h11111111, 1'b0, 16'd1};
    run(v, 1'b1, "midrst3");

    // Hold with the pointer at requester 1: pointer must not move while held.
    v = '{1'b1, 1'b1, 2'b11, 5'd1, 5'd2, 32'h11111111, 32'h22222222, 2'b00, 1'b0, 5'd1, 32'h11111111, 1'b0, 16'd1};
    run(v, 1'b1, "hold1a");
    v = '{1'b1, 1'b0, 2'b11, 5'd1, 5'd2, 32'h11111111, 32'h22222222, 2'b10, 1'b0, 5'd1, 32'h11111111, 1'b0, 16'd1};
    run(v, 1'b1, "hold1b");
    v = '{1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 1'b1, 5'd2, 32'h22222222, 1'b1, 16'd2};
    run(v, 1'b1, "hold1c");

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      v       = '{1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 1'b0, 5'd0, 32'h0, 1'b0, 16'd0};
      v.rst   = ($urandom_range(0, 59) != 0);
      v.hold  = ($urandom_range(0, 4) == 0);
      v.valid = 2'($urandom_range(0, 3));
      v.i0    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      v.i1    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      v.d0    = $urandom;
      v.d1    = $urandom;
      run(v, 1'b0, $sformatf("rnd%0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
